fetch_pc_gen: RTL

Registered fetch-stage program counter with next-PC selection for the pipelined MIPS core. It is the parametrised successor of the combinational next-PC selector and owns the F-stage PC register. It adds configurable reset and exception vectors and a selectable ERET return mode. It also adds an instruction-memory ready handshake with a pending-redirect buffer, misaligned-fetch detection and a taken-redirect counter. It sits between the hazard/CP0 units and instruction memory; pc_f feeds IM and the F/D pipeline register.

---
 rtl/fetch_pc_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: F-stage program counter register with next-PC selection,
// instruction-memory ready handshake, pending-redirect buffer,
// misaligned-fetch flag and a counter of applied non-sequential updates.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter bit          ERET_PLUS4 = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             imem_ready,
    input  logic [31:0]      pc_d,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      ra_data,
    input  logic [2:0]       npc_op,
    input  logic             cmp_zero,
    input  logic             eret_d,
    input  logic             req,
    input  logic [31:0]      epc,
    output logic [31:0]      pc_f,
    output logic             pc_valid,
    output logic             adel_f,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] OP_BEQ = 3'd1;
    localparam logic [2:0] OP_J   = 3'd2;
    localparam logic [2:0] OP_JR  = 3'd3;
    localparam logic [2:0] OP_BNE = 3'd4;

    state_t           state_q, state_n;
    logic [31:0]      pc_q, pc_n;
    logic [31:0]      pend_q, pend_n;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;

    logic [31:0] seq_tgt;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic [31:0] eret_tgt;
    logic [31:0] redir_tgt;
    logic        taken;

    // Opcode field of the D instruction is not needed for target generation.
    logic unused_bits;
    assign unused_bits = ^instr_d[31:26];

    assign seq_tgt  = pc_q + 32'd4;
    assign br_tgt   = pc_d + 32'd4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign jmp_tgt  = {pc_q[31:28], instr_d[25:0], 2'b00};
    assign eret_tgt = ERET_PLUS4 ? (epc + 32'd4) : epc;

    // Redirect decision and target for the instruction in D (eret over npc_op).
    always_comb begin
        taken     = 1'b0;
        redir_tgt = seq_tgt;
        if (eret_d) begin
            taken     = 1'b1;
            redir_tgt = eret_tgt;
        end else begin
            case (npc_op)
                OP_BEQ: begin
                    taken     = cmp_zero;
                    redir_tgt = br_tgt;
                end
                OP_BNE: begin
                    taken     = ~cmp_zero;
                    redir_tgt = br_tgt;
                end
                OP_J: begin
                    taken     = 1'b1;
                    redir_tgt = jmp_tgt;
                end
                OP_JR: begin
                    taken     = 1'b1;
                    redir_tgt = ra_data;
                end
                default: begin
                    taken     = 1'b0;
                    redir_tgt = seq_tgt;
                end
            endcase
        end
    end

    // Next-state, next-PC and pending-buffer selection; req dominates everything.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        pend_n  = pend_q;
        cnt_inc = 1'b0;
        if (req) begin
            pc_n    = EXC_VECTOR;
            pend_n  = '0;
            state_n = ST_RUN;
            cnt_inc = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall_f) begin
                        if (imem_ready) begin
                            pc_n    = taken ? redir_tgt : seq_tgt;
                            cnt_inc = taken;
                        end else if (taken) begin
                            // Memory not ready: park the redirect, PC holds.
                            pend_n  = redir_tgt;
                            state_n = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_ready && !stall_f) begin
                        pc_n    = pend_q;
                        pend_n  = '0;
                        state_n = ST_RUN;
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_RUN;
                end
            endcase
        end
    end

    // State, PC, pending target and redirect counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            pend_q  <= pend_n;
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Fetch request becomes valid on the first edge after reset and stays valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b1;
        end
    end

    assign pc_f             = pc_q;
    assign pc_valid         = valid_q;
    assign adel_f           = |pc_q[1:0];
    assign redirect_pending = (state_q == ST_WAIT);
    assign redirect_cnt     = cnt_q;

endmodule
